reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
// - Parametrised multi-port integer register file with an integrated busy scoreboard; successor to the 2R/1W file.
// - Adds N read / M write ports, same-cycle write->read bypass, optional registered reads, optional hardwired x0.
// - Adds per-register busy bits for hazard detection in the dual-issue decode/writeback stages.
// PARAMETERS
// - DATA_WIDTH   32  width of each register
// - ADDR_WIDTH   5   register index width; DEPTH = 2**ADDR_WIDTH
// - NUM_RD       2   read ports (1..4)
// - NUM_WR       2   write ports (1..2)
// - BYPASS       1   1: a write in the current cycle is forwarded to matching reads; 0: reads return stored value only
// - RD_LATENCY   0   0: combinational read; 1: rd_data/rd_busy registered (1-cycle latency)
// - ZERO_REG     1   1: index 0 reads 0, ignores writes, is never busy
// PORTS
// - clk          in   1                    clock, all state on rising edge
// - rst          in   1                    asynchronous, active-high reset
// - wr_en        in   NUM_WR               per-port write enable
// - wr_addr      in   NUM_WR*ADDR_WIDTH    write index, port j at [j*AW +: AW]
// - wr_data      in   NUM_WR*DATA_WIDTH    write data, port j at [j*DW +: DW]
// - rd_addr      in   NUM_RD*ADDR_WIDTH    read index, port i at [i*AW +: AW]
// - rd_data      out  NUM_RD*DATA_WIDTH    read data
// - rd_busy      out  NUM_RD               busy bit of the register addressed by read port i
// - sb_set_en    in   1                    mark sb_set_addr busy (producer issued)
// - sb_set_addr  in   ADDR_WIDTH           register to mark busy
// - sb_flush     in   1                    clear all busy bits (pipeline flush)
// BEHAVIOUR
// - Reset (rst=1, asynchronous): all registers 0; all busy bits 0; registered rd_data/rd_busy 0. Takes effect mid-operation.
// - Write: on posedge, for each j with wr_en[j], reg[wr_addr[j]] <= wr_data[j].
// - Two ports writing the same index in one cycle: highest port index wins.
// - ZERO_REG=1: index 0 writes are dropped; reads of index 0 return 0 and rd_busy=0.
// - Read value, RD_LATENCY=0: combinational stored value.
// - BYPASS=1, RD_LATENCY=0: if any wr_en[j] && wr_addr[j]==rd_addr[i] (and not zero-reg), output wr_data of the highest matching j.
// - RD_LATENCY=1: the same selection is sampled at posedge and presented the following cycle.
// - BYPASS=0 with RD_LATENCY=1: the pre-write value is captured.
// - Busy bits: busy[k] set at posedge by sb_set_en with sb_set_addr==k; cleared at posedge by any wr_en[j] with wr_addr[j]==k.
// - Same cycle set and write-clear of the same k: set wins (busy stays 1; new producer).
// - sb_flush clears every busy bit at posedge; a simultaneous sb_set_en is applied after the flush (that bit ends 1).
// - rd_busy[i] = busy[rd_addr[i]]; with BYPASS=1 it is forced 0 when a same-cycle write matches rd_addr[i].
// - rd_busy follows RD_LATENCY identically to rd_data.
// - No arithmetic; no X propagation; out-of-range parameters are an elaboration error (generate-time check).
// TESTING
// - Reset then read all indices on every port -> rd_data=0, rd_busy=0; assert rst mid-write -> reg and busy cleared immediately.
// - wr0 x5=0xDEADBEEF, next cycle read x5 on ports 0 and 1 -> 0xDEADBEEF on both; write x0=0x1234 -> reads 0 (ZERO_REG=1).
// - Same cycle wr0 x7=0x11, wr1 x7=0x22 -> x7=0x22 thereafter.
// - BYPASS=1: write x3=0xAA while reading x3 -> rd_data=0xAA same cycle; BYPASS=0 -> old value, 0xAA next cycle.
// - Scoreboard: set x9 -> rd_busy=1 next cycle; write x9 -> busy 0; set and write x9 together -> stays 1; flush with set x4 -> only x4 busy.
// - RD_LATENCY=1: read x5 after write -> value appears exactly one cycle after address presented; reset forces rd_data=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with an integrated busy scoreboard.
//
// Purpose
//   NUM_RD read ports and NUM_WR write ports over DEPTH = 2**ADDR_WIDTH registers.
//   Optional same-cycle write->read bypass, optional registered reads, and an
//   optional hardwired zero register at index 0. Each register carries a busy bit
//   for hazard detection: it is set when a producer issues and cleared by the
//   write that retires it.
//
// Ports
//   clk          in   1                   rising-edge clock
//   rst          in   1                   asynchronous active-high reset
//   wr_en        in   NUM_WR              per-port write enable
//   wr_addr      in   NUM_WR*ADDR_WIDTH   write index, port j at [j*AW +: AW]
//   wr_data      in   NUM_WR*DATA_WIDTH   write data, port j at [j*DW +: DW]
//   rd_addr      in   NUM_RD*ADDR_WIDTH   read index, port i at [i*AW +: AW]
//   rd_data      out  NUM_RD*DATA_WIDTH   read data, port i at [i*DW +: DW]
//   rd_busy      out  NUM_RD              busy bit of the register addressed by port i
//   sb_set_en    in   1                   mark sb_set_addr busy
//   sb_set_addr  in   ADDR_WIDTH          register to mark busy
//   sb_flush     in   1                   clear every busy bit
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int RD_LATENCY = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         sb_set_en,
  input  logic [ADDR_WIDTH-1:0]        sb_set_addr,
  input  logic                         sb_flush
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
    $error("reg_file_mp: NUM_WR must be 1..2");
  end
  if (BYPASS < 0 || BYPASS > 1 || RD_LATENCY < 0 || RD_LATENCY > 1 ||
      ZERO_REG < 0 || ZERO_REG > 1) begin : g_bad_flags
    $error("reg_file_mp: BYPASS, RD_LATENCY and ZERO_REG must be 0 or 1");
  end
  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_widths
    $error("reg_file_mp: DATA_WIDTH and ADDR_WIDTH must be positive");
  end

  logic [DW-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     busy_nxt;
  logic [NUM_RD*DW-1:0] sel_data_p0;
  logic [NUM_RD-1:0]    sel_busy_p0;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Ascending port order makes the highest-numbered port's assignment land last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !is_zero(wr_addr[j*AW +: AW]))
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
      end
    end
  end

  // Write-clear first, then flush, then set: a new producer issued this cycle
  // always ends busy, even against a retiring write or a flush.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (sb_flush) busy_nxt = '0;
    if (sb_set_en && !is_zero(sb_set_addr)) busy_nxt[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Stage p0: read selection (stored value, optional bypass, zero register).
  always_comb begin
    sel_data_p0 = '0;
    sel_busy_p0 = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      sel_data_p0[i*DW +: DW] = regs[rd_addr[i*AW +: AW]];
      sel_busy_p0[i]          = busy[rd_addr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            sel_data_p0[i*DW +: DW] = wr_data[j*DW +: DW];
            sel_busy_p0[i]          = 1'b0;
          end
        end
      end
      if (is_zero(rd_addr[i*AW +: AW])) begin
        sel_data_p0[i*DW +: DW] = '0;
        sel_busy_p0[i]          = 1'b0;
      end
    end
  end

  if (RD_LATENCY == 0) begin : g_comb_rd
    assign rd_data = sel_data_p0;
    assign rd_busy = sel_busy_p0;
  end else begin : g_reg_rd
    logic [NUM_RD*DW-1:0] rd_data_p1;
    logic [NUM_RD-1:0]    rd_busy_p1;

    // Stage p1: registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_p1 <= '0;
        rd_busy_p1 <= '0;
      end else begin
        rd_data_p1 <= sel_data_p0;
        rd_busy_p1 <= sel_busy_p0;
      end
    end

    assign rd_data = rd_data_p1;
    assign rd_busy = rd_busy_p1;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives two register files from the same stimulus, one with
// bypass and combinational reads, one without bypass and with registered reads.
// Expected read results come from an array model of the register contents and
// busy bits; a negedge monitor compares outputs against queued expectations.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NW-1:0]     wr_en = '0;
  logic [NW*AW-1:0]  wr_addr = '0;
  logic [NW*DW-1:0]  wr_data = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;
  logic [NR-1:0]     rd_busy_a, rd_busy_b;
  logic              sb_set_en = 1'b0;
  logic [AW-1:0]     sb_set_addr = '0;
  logic              sb_flush = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(1), .RD_LATENCY(0), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush));

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(0), .RD_LATENCY(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush));

  typedef struct packed {
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [DW-1:0] m_regs [32];
  logic          m_busy [32];
  logic          prev_rst = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  // What a read of address a should return, with or without forwarding.
  task automatic model_read(input logic [AW-1:0] a, input bit byp,
                            output logic [DW-1:0] d, output logic b);
    d = m_regs[a];
    b = m_busy[a];
    if (byp) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*DW +: DW];
          b = 1'b0;
        end
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
    for (int j = 0; j < NW; j++)
      if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
    if (sb_flush) for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
  endtask

  // Called #1 after a rising edge with this cycle's inputs already applied.
  task automatic step();
    exp_t ea, eb;
    logic [DW-1:0] d;
    logic b;
    if (rst) model_clear();
    ea = '0;
    eb = '0;
    for (int i = 0; i < NR; i++) begin
      model_read(rd_addr[i*AW +: AW], 1'b1, d, b);
      ea.d[i*DW +: DW] = d;
      ea.b[i] = b;
      model_read(rd_addr[i*AW +: AW], 1'b0, d, b);
      if (!rst) begin
        eb.d[i*DW +: DW] = d;
        eb.b[i] = b;
      end
    end
    // A freshly asserted reset zeroes the registered outputs at once.
    if (rst && !prev_rst) begin
      qb.delete();
      qb.push_back('0);
    end
    qa.push_back(ea);
    qb.push_back(eb);
    prev_rst = rst;
    @(posedge clk);
    if (rst) model_clear();
    else     model_update();
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      for (int i = 0; i < NR; i++) begin
        check($sformatf("a_data%0d", i), rd_data_a[i*DW +: DW], e.d[i*DW +: DW]);
        check($sformatf("a_busy%0d", i), {31'b0, rd_busy_a[i]}, {31'b0, e.b[i]});
      end
    end
    if (qb.size() >= 2) begin
      e = qb.pop_front();
      for (int i = 0; i < NR; i++) begin
        check($sformatf("b_data%0d", i), rd_data_b[i*DW +: DW], e.d[i*DW +: DW]);
        check($sformatf("b_busy%0d", i), {31'b0, rd_busy_b[i]}, {31'b0, e.b[i]});
      end
    end
  end

  task automatic idle();
    wr_en = '0;
    sb_set_en = 1'b0;
    sb_flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] v);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = v;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd(AW'(k), AW'(31 - k));
      step();
    end

    wr(0, 5, 32'hDEADBEEF); rd(5, 5); step();
    idle(); step();
    wr(1, 0, 32'h1234); rd(0, 5); step();
    idle(); rd(0, 0); step();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(7, 1); step();
    idle(); rd(7, 7); step();
    wr(0, 3, 32'hAA); rd(3, 3); step();
    idle(); step();
    sb_set_en = 1'b1; sb_set_addr = 9; rd(9, 4); step();
    idle(); step();
    wr(1, 9, 32'h99); step();
    idle(); step();
    sb_set_en = 1'b1; sb_set_addr = 9; wr(0, 9, 32'h9A); step();
    idle(); step();
    sb_set_en = 1'b1; sb_set_addr = 12; step();
    idle(); rd(9, 12); step();
    sb_flush = 1'b1; sb_set_en = 1'b1; sb_set_addr = 4; rd(4, 9); step();
    idle(); rd(4, 12); step();
    step();

    // Reset arriving mid-cycle while a write and busy state are pending.
    sb_set_en = 1'b1; sb_set_addr = 5; step();
    idle(); wr(0, 5, 32'hCAFE0001); rd(5, 9); rst = 1'b1; step();
    idle(); rst = 1'b0; step();
    step();

    for (int n = 0; n < 1500; n++) begin
      idle();
      for (int j = 0; j < NW; j++) begin
        if ($urandom_range(0, 1) == 1) wr(j, raddr(), $urandom());
        else wr_addr[j*AW +: AW] = raddr();
      end
      rd(raddr(), raddr());
      sb_set_en   = ($urandom_range(0, 2) == 0);
      sb_set_addr = raddr();
      sb_flush    = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end

    idle();
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
